seq_div_8by4: RTL and testbench



---
 rtl/seq_div_8by4.sv | 118 +++++++++++
 tb/tb_seq_div_8by4.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_div_8by4.sv
// Iterative restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// start/busy/done handshake; results and divide-by-zero flag are held until the next completion.
module seq_div_8by4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] count;
    logic [DW-1:0] shift_q;   // dividend bits shift out the top, quotient bits shift in the bottom
    logic [VW-1:0] prem;
    logic [VW-1:0] dsr;

    logic          accept;
    logic          div_zero;
    logic          last;
    logic [VW:0]   trial;     // one bit wider than the divisor so the compare never overflows
    logic          fits;
    logic [VW-1:0] diff;
    logic [VW-1:0] prem_nx;
    logic [DW-1:0] quot_nx;

    assign accept   = start && (state != RUN);
    assign div_zero = (divisor == '0);
    assign last     = (count == '0);

    assign trial   = {prem, shift_q[DW-1]};
    assign fits    = (trial >= {1'b0, dsr});
    assign diff    = VW'(trial - {1'b0, dsr});
    assign prem_nx = fits ? diff : trial[VW-1:0];
    assign quot_nx = {shift_q[DW-2:0], fits};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: next state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = div_zero ? DONE : RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (accept) state_nx = div_zero ? DONE : RUN;
                else        state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the working registers are reset along with the outputs so an aborted
    // division leaves no stale partial state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            shift_q   <= '0;
            prem      <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else if (accept) begin
            count   <= CW'(DW - 1);
            shift_q <= dividend;
            prem    <= '0;
            dsr     <= divisor;
            if (div_zero) begin
                quotient  <= '1;
                remainder <= '0;
                dz        <= 1'b1;
            end
        end else if (state == RUN) begin
            count   <= count - 1'b1;
            shift_q <= quot_nx;
            prem    <= prem_nx;
            if (last) begin
                quotient  <= quot_nx;
                remainder <= prem_nx;
                dz        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_div_8by4.sv
// Self-checking bench for seq_div_8by4: directed cases, handshake/reset cases and an
// exhaustive shuffled back-to-back sweep compared against plain-arithmetic division.
module tb_seq_div_8by4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dz;

    int checks = 0;
    int errors = 0;

    seq_div_8by4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: {dz, quotient, remainder} from ordinary unsigned division.
    function automatic logic [12:0] ref_div(input logic [7:0] a, input logic [3:0] b);
        if (b == 0) return {1'b1, 8'hFF, 4'h0};
        return {1'b0, 8'(a / b), 4'(a % b)};
    endfunction

    // The companion multiplier's behaviour, used for the round-trip check.
    function automatic int mul(input int x, input int y);
        return x * y;
    endfunction

    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // lat = number of rising edges after the accepting edge before done is seen.
    task automatic await_done(input bit glitch, output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = n;
                break;
            end
            if (glitch) begin
                if (n == 1 || n == 4) begin
                    start    = 1'b1;
                    dividend = 8'd250;
                    divisor  = 4'd3;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [7:0] a, input logic [3:0] b,
                            input bit glitch);
        int          lat;
        int          busy_n;
        logic [12:0] exp;
        exp = ref_div(a, b);
        launch(a, b);
        await_done(glitch, lat, busy_n);
        check({tag, "_lat"}, lat, (b == 0) ? 0 : 8);
        check({tag, "_busy"}, busy_n, (b == 0) ? 0 : 8);
        check({tag, "_q"}, quotient, exp[11:4]);
        check({tag, "_r"}, remainder, exp[3:0]);
        check({tag, "_dz"}, dz, exp[12]);
        @(negedge clk);
        check({tag, "_pulse"}, done, 0);
    endtask

    int pairs[3840];

    initial begin
        int          lat;
        int          busy_n;
        logic [7:0]  a;
        logic [3:0]  b;
        logic [12:0] exp;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", dz, 0);
        rst_n = 1'b1;

        run_case("nominal", 8'd200, 4'd7, 1'b0);
        run_case("max_q", 8'd255, 4'd1, 1'b0);
        run_case("small", 8'd13, 4'd15, 1'b0);
        run_case("zero_num", 8'd0, 4'd5, 1'b0);
        run_case("roundtrip", 8'd225, 4'd15, 1'b0);
        run_case("divzero", 8'd99, 4'd0, 1'b0);
        run_case("clear_dz", 8'd10, 4'd3, 1'b0);
        run_case("ignored_start", 8'd100, 4'd9, 1'b0 | 1'b1);

        repeat (3) @(negedge clk);
        check("hold_q", quotient, 11);
        check("hold_r", remainder, 1);

        // Asynchronous reset between edges in the middle of a run.
        launch(8'd77, 8'd6);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_q", quotient, 0);
        check("arst_r", remainder, 0);
        check("arst_dz", dz, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_case("after_rst", 8'd77, 4'd6, 1'b0);

        // Every nonzero-divisor pair, shuffled, with start held high (back-to-back).
        for (int i = 0; i < 3840; i++) pairs[i] = i;
        for (int i = 3839; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = t;
        end

        @(negedge clk);
        a = 8'(pairs[0] / 15);
        b = 4'(pairs[0] % 15 + 1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int k = 0; k < 3840; k++) begin
            @(posedge clk);
            lat = -1;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (done) begin
                    lat = n;
                    break;
                end
            end
            exp = ref_div(a, b);
            check("b2b_lat", lat, 8);
            check("b2b_q", quotient, exp[11:4]);
            check("b2b_r", remainder, exp[3:0]);
            check("b2b_inv", mul(int'(quotient), int'(b)) + int'(remainder), int'(a));
            check("b2b_rlt", remainder < b, 1);
            if (lat < 0) break;
            if (k < 3839) begin
                a = 8'(pairs[k + 1] / 15);
                b = 4'(pairs[k + 1] % 15 + 1);
                dividend = a;
                divisor  = b;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("b2b_end_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
